// File: rtl/tmds_encoder_multi.sv
// Multi-channel TMDS symbol encoder: video (8b/10b with running disparity),
// control, TERC4 and guard-band symbols through a 2-stage, clock-enabled pipeline.
`timescale 1ns/1ps
module tmds_encoder_multi #(
  parameter int CHANNELS = 3,
  parameter bit TERC4_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [CHANNELS*8-1:0] data,
  input  logic [CHANNELS*2-1:0] ctrl,
  input  logic [CHANNELS*4-1:0] aux,
  output logic [CHANNELS*10-1:0] sym,
  output logic                  valid_out,
  output logic [CHANNELS*5-1:0] disparity
);

  localparam logic [1:0] MODE_VIDEO = 2'b00;
  localparam logic [1:0] MODE_CTRL  = 2'b01;
  localparam logic [1:0] MODE_TERC4 = 2'b10;
  localparam logic [1:0] MODE_GUARD = 2'b11;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    case (c)
      2'b00:   ctrl_token = 10'b1101010100;
      2'b01:   ctrl_token = 10'b0010101011;
      2'b10:   ctrl_token = 10'b0101010100;
      default: ctrl_token = 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] terc4_token(input logic [3:0] a);
    case (a)
      4'h0:    terc4_token = 10'b1010011100;
      4'h1:    terc4_token = 10'b1001100011;
      4'h2:    terc4_token = 10'b1011100100;
      4'h3:    terc4_token = 10'b1011100010;
      4'h4:    terc4_token = 10'b0101110001;
      4'h5:    terc4_token = 10'b0100011110;
      4'h6:    terc4_token = 10'b0110001110;
      4'h7:    terc4_token = 10'b0100111100;
      4'h8:    terc4_token = 10'b1011001100;
      4'h9:    terc4_token = 10'b0100111001;
      4'hA:    terc4_token = 10'b0110011100;
      4'hB:    terc4_token = 10'b1011000110;
      4'hC:    terc4_token = 10'b1010001110;
      4'hD:    terc4_token = 10'b1001110001;
      4'hE:    terc4_token = 10'b0101100011;
      default: terc4_token = 10'b1011000011;
    endcase
  endfunction

  // Shared stage-1 state; the reset value of r_mode1 makes a flushed
  // pipeline emit control token 00.
  logic [1:0] r_mode1;
  logic       r_v1;
  logic       r_v2;
  logic [1:0] w_mode_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode1 <= MODE_CTRL;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
    end else if (en) begin
      r_mode1 <= mode;
      r_v1    <= 1'b1;
      r_v2    <= r_v1;
    end
  end

  always_comb begin
    w_mode_eff = r_mode1;
    if ((r_mode1 == MODE_TERC4) && !TERC4_EN) w_mode_eff = MODE_CTRL;
  end

  assign valid_out = r_v2;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    localparam logic [9:0] GUARD_SYM = ((g % 2) == 0) ? 10'b1011001100 : 10'b0100110011;

    logic [7:0]        w_d;
    logic [3:0]        w_n1d;
    logic              w_xnor;
    logic [8:0]        w_qm;
    logic [3:0]        w_n1q;
    logic [8:0]        r_qm;
    logic [3:0]        r_n1q;
    logic [1:0]        r_ctrl;
    logic [3:0]        r_aux;
    logic [9:0]        r_sym;
    logic signed [4:0] r_cnt;
    logic [9:0]        w_sym_nxt;
    logic signed [4:0] w_cnt_nxt;
    logic signed [4:0] w_diff;

    assign w_d = data[8*g +: 8];

    always_comb begin
      w_n1d = '0;
      for (int b = 0; b < 8; b++) w_n1d = w_n1d + 4'(w_d[b]);
      w_xnor = (w_n1d > 4'd4) || ((w_n1d == 4'd4) && !w_d[0]);
      w_qm    = '0;
      w_qm[0] = w_d[0];
      for (int b = 1; b < 8; b++)
        w_qm[b] = w_xnor ? ~(w_qm[b-1] ^ w_d[b]) : (w_qm[b-1] ^ w_d[b]);
      w_qm[8] = ~w_xnor;
      w_n1q = '0;
      for (int b = 0; b < 8; b++) w_n1q = w_n1q + 4'(w_qm[b]);
    end

    // N1-N0 = 2*N1-8; computed modulo 32, exact over its -8..8 range.
    assign w_diff = $signed({r_n1q, 1'b0}) - 5'sd8;

    always_comb begin
      w_sym_nxt = CTRL_TOKEN_00;
      w_cnt_nxt = '0;
      case (w_mode_eff)
        MODE_VIDEO: begin
          if ((r_cnt == 5'sd0) || (r_n1q == 4'd4)) begin
            w_sym_nxt = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + (r_qm[8] ? w_diff : -w_diff);
          end else if ((!r_cnt[4] && (r_n1q > 4'd4)) || (r_cnt[4] && (r_n1q < 4'd4))) begin
            w_sym_nxt = {1'b1, r_qm[8], ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + (r_qm[8] ? 5'sd2 : 5'sd0) - w_diff;
          end else begin
            w_sym_nxt = {1'b0, r_qm[8], r_qm[7:0]};
            w_cnt_nxt = r_cnt + w_diff - (r_qm[8] ? 5'sd0 : 5'sd2);
          end
        end
        MODE_CTRL:  w_sym_nxt = ctrl_token(r_ctrl);
        MODE_TERC4: w_sym_nxt = terc4_token(r_aux);
        MODE_GUARD: w_sym_nxt = GUARD_SYM;
        default:    w_sym_nxt = CTRL_TOKEN_00;
      endcase
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_qm   <= '0;
        r_n1q  <= '0;
        r_ctrl <= '0;
        r_aux  <= '0;
        r_sym  <= CTRL_TOKEN_00;
        r_cnt  <= '0;
      end else if (en) begin
        r_qm   <= w_qm;
        r_n1q  <= w_n1q;
        r_ctrl <= ctrl[2*g +: 2];
        r_aux  <= aux[4*g +: 4];
        r_sym  <= w_sym_nxt;
        r_cnt  <= w_cnt_nxt;
      end
    end

    assign sym[10*g +: 10]      = r_sym;
    assign disparity[5*g +: 5] = r_cnt;
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Bench for tmds_encoder_multi: a 4-channel TERC4 instance and a 3-channel
// TERC4-disabled instance fed the same pixels, checked against tables and a model.
`timescale 1ns/1ps
module tb_tmds_encoder_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [31:0] data;
  logic [7:0]  ctrl;
  logic [15:0] aux;
  logic [39:0] sym4;
  logic [19:0] disp4;
  logic        valid4;
  logic [29:0] sym3;
  logic [14:0] disp3;
  logic        valid3;

  always #5 clk = ~clk;

  tmds_encoder_multi #(.CHANNELS(4), .TERC4_EN(1'b1)) u_dut4 (
    .clk(clk), .rst(rst_n), .en(en), .mode(mode), .data(data), .ctrl(ctrl), .aux(aux),
    .sym(sym4), .valid_out(valid4), .disparity(disp4)
  );

  tmds_encoder_multi #(.CHANNELS(3), .TERC4_EN(1'b0)) u_dut3 (
    .clk(clk), .rst(rst_n), .en(en), .mode(mode), .data(data[23:0]), .ctrl(ctrl[5:0]),
    .aux(aux[11:0]), .sym(sym3), .valid_out(valid3), .disparity(disp3)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [9:0] terc_tab [16];
  logic [9:0] ctrl_tab [4];

  // reference model state
  int          cnt4 [4];
  int          cnt3 [3];
  int          exp_sym4 [4];
  int          exp_disp4 [4];
  int          exp_sym3 [3];
  int          exp_disp3 [3];
  int          en_edges;
  logic [1:0]  p_mode;
  logic [31:0] p_data;
  logic [7:0]  p_ctrl;
  logic [15:0] p_aux;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] d;
    logic [1:0] c;
    logic [3:0] a;
    logic [9:0] exp_even;
    logic [9:0] exp_odd;
    int         exp_disp;
  } vec_t;

  vec_t tbl [24];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int ref_encode(input logic [1:0] m, input logic [7:0] d, input logic [1:0] c,
                                    input logic [3:0] a, input int ch, input bit terc, inout int cnt);
    int         n1d;
    int         ones;
    int         zeros;
    bit         use_xnor;
    logic [8:0] qm;
    logic [9:0] s;
    if (m == 2'b00) begin
      n1d      = $countones(d);
      use_xnor = (n1d > 4) || ((n1d == 4) && (d[0] == 1'b0));
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = !use_xnor;
      ones  = $countones(qm[7:0]);
      zeros = 8 - ones;
      if ((cnt == 0) || (ones == zeros)) begin
        s   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        cnt = cnt + (qm[8] ? (ones - zeros) : (zeros - ones));
      end else if (((cnt > 0) && (ones > zeros)) || ((cnt < 0) && (zeros > ones))) begin
        s   = {1'b1, qm[8], ~qm[7:0]};
        cnt = cnt + (qm[8] ? 2 : 0) + zeros - ones;
      end else begin
        s   = {1'b0, qm[8], qm[7:0]};
        cnt = cnt + ones - zeros - (qm[8] ? 0 : 2);
      end
    end else begin
      cnt = 0;
      if (m == 2'b01) s = ctrl_tab[c];
      else if (m == 2'b10) s = terc ? terc_tab[a] : ctrl_tab[c];
      else s = ((ch % 2) == 0) ? 10'h2CC : 10'h133;
    end
    return 32'(s);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      cnt4[ch] = 0; exp_sym4[ch] = 'h354; exp_disp4[ch] = 0;
    end
    for (int ch = 0; ch < 3; ch++) begin
      cnt3[ch] = 0; exp_sym3[ch] = 'h354; exp_disp3[ch] = 0;
    end
    en_edges = 0;
    p_mode = 2'b01; p_data = '0; p_ctrl = '0; p_aux = '0;
  endtask

  task automatic model_step();
    int t;
    for (int ch = 0; ch < 4; ch++) begin
      t = cnt4[ch];
      exp_sym4[ch]  = ref_encode(p_mode, p_data[8*ch +: 8], p_ctrl[2*ch +: 2], p_aux[4*ch +: 4], ch, 1'b1, t);
      cnt4[ch]      = t;
      exp_disp4[ch] = t;
    end
    for (int ch = 0; ch < 3; ch++) begin
      t = cnt3[ch];
      exp_sym3[ch]  = ref_encode(p_mode, p_data[8*ch +: 8], p_ctrl[2*ch +: 2], p_aux[4*ch +: 4], ch, 1'b0, t);
      cnt3[ch]      = t;
      exp_disp3[ch] = t;
    end
    en_edges++;
    p_mode = mode; p_data = data; p_ctrl = ctrl; p_aux = aux;
  endtask

  // Drive on the falling edge, model on the rising edge, leave time at posedge+1 for checks.
  task automatic step(input logic e, input logic [1:0] m, input logic [31:0] d,
                      input logic [7:0] c, input logic [15:0] a);
    @(negedge clk);
    en = e; mode = m; data = d; ctrl = c; aux = a;
    @(posedge clk);
    if (rst_n && e) model_step();
    #1;
  endtask

  task automatic check_model();
    int dv;
    check("dut4_valid", int'(valid4), (en_edges >= 2) ? 1 : 0);
    check("dut3_valid", int'(valid3), (en_edges >= 2) ? 1 : 0);
    for (int ch = 0; ch < 4; ch++) begin
      dv = int'($signed(disp4[5*ch +: 5]));
      check($sformatf("dut4_sym_ch%0d", ch), int'(sym4[10*ch +: 10]), exp_sym4[ch]);
      check($sformatf("dut4_disp_ch%0d", ch), dv, exp_disp4[ch]);
      check($sformatf("dut4_disp_bound_ch%0d", ch), ((dv <= 10) && (dv >= -10)) ? 1 : 0, 1);
    end
    for (int ch = 0; ch < 3; ch++) begin
      dv = int'($signed(disp3[5*ch +: 5]));
      check($sformatf("dut3_sym_ch%0d", ch), int'(sym3[10*ch +: 10]), exp_sym3[ch]);
      check($sformatf("dut3_disp_ch%0d", ch), dv, exp_disp3[ch]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid4"}, int'(valid4), 0);
    check({tag, "_valid3"}, int'(valid3), 0);
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("%s_sym4_ch%0d", tag, ch), int'(sym4[10*ch +: 10]), 'h354);
      check($sformatf("%s_disp4_ch%0d", tag, ch), int'(disp4[5*ch +: 5]), 0);
    end
    for (int ch = 0; ch < 3; ch++) begin
      check($sformatf("%s_sym3_ch%0d", tag, ch), int'(sym3[10*ch +: 10]), 'h354);
      check($sformatf("%s_disp3_ch%0d", tag, ch), int'(disp3[5*ch +: 5]), 0);
    end
  endtask

  task automatic check_tbl(input int i);
    for (int ch = 0; ch < 4; ch++) begin
      check($sformatf("tbl%0d_sym_ch%0d", i, ch), int'(sym4[10*ch +: 10]),
            int'(((ch % 2) == 0) ? tbl[i].exp_even : tbl[i].exp_odd));
      check($sformatf("tbl%0d_disp_ch%0d", i, ch), int'($signed(disp4[5*ch +: 5])), tbl[i].exp_disp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    terc_tab[0]  = 10'h29C; terc_tab[1]  = 10'h263; terc_tab[2]  = 10'h2E4; terc_tab[3]  = 10'h2E2;
    terc_tab[4]  = 10'h171; terc_tab[5]  = 10'h11E; terc_tab[6]  = 10'h18E; terc_tab[7]  = 10'h13C;
    terc_tab[8]  = 10'h2CC; terc_tab[9]  = 10'h139; terc_tab[10] = 10'h19C; terc_tab[11] = 10'h2C6;
    terc_tab[12] = 10'h28E; terc_tab[13] = 10'h271; terc_tab[14] = 10'h163; terc_tab[15] = 10'h2C3;
    ctrl_tab[0] = 10'h354; ctrl_tab[1] = 10'h0AB; ctrl_tab[2] = 10'h154; ctrl_tab[3] = 10'h2AB;

    tbl[0] = '{2'b00, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100, -8};
    tbl[1] = '{2'b00, 8'h00, 2'b00, 4'h0, 10'h3FF, 10'h3FF, 2};
    tbl[2] = '{2'b00, 8'h00, 2'b00, 4'h0, 10'h100, 10'h100, -6};
    tbl[3] = '{2'b01, 8'h00, 2'b00, 4'h0, 10'h354, 10'h354, 0};
    tbl[4] = '{2'b00, 8'hFF, 2'b00, 4'h0, 10'h200, 10'h200, -8};
    tbl[5] = '{2'b01, 8'h00, 2'b01, 4'h0, 10'h0AB, 10'h0AB, 0};
    tbl[6] = '{2'b11, 8'h00, 2'b00, 4'h0, 10'h2CC, 10'h133, 0};
    for (int i = 0; i < 16; i++)
      tbl[7+i] = '{2'b10, 8'h00, 2'b00, 4'(i), terc_tab[i], terc_tab[i], 0};
    tbl[23] = '{2'b01, 8'h00, 2'b11, 4'h0, 10'h2AB, 10'h2AB, 0};

    // reset held low
    rst_n = 1'b0; en = 1'b0; mode = 2'b01; data = '0; ctrl = '0; aux = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");

    // release with en=1, control 00: valid after two edges
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 2'b01, '0, '0, '0);
    check("valid_after_1_edge", int'(valid4), 0);
    check_model();
    step(1'b1, 2'b01, '0, '0, '0);
    check("valid_after_2_edges", int'(valid4), 1);
    check_model();

    // directed table: output for entry i-1 appears while entry i is applied
    for (int i = 0; i < 24; i++) begin
      step(1'b1, tbl[i].mode, {4{tbl[i].d}}, {4{tbl[i].c}}, {4{tbl[i].a}});
      if (i > 0) check_tbl(i - 1);
      check_model();
    end
    step(1'b1, 2'b01, '0, '0, '0);
    check_tbl(23);

    // TERC4 disabled: mode 10 yields control tokens from ctrl
    step(1'b1, 2'b10, '0, {4{2'b10}}, {4{4'h5}});
    step(1'b1, 2'b11, '0, '0, '0);
    check("terc4_off_ch0", int'(sym3[9:0]), 'h154);
    check("terc4_on_ch0", int'(sym4[9:0]), 'h11E);
    check_model();
    step(1'b1, 2'b01, '0, '0, '0);
    check("guard3_ch0", int'(sym3[9:0]), 'h2CC);
    check("guard3_ch1", int'(sym3[19:10]), 'h133);
    check("guard3_ch2", int'(sym3[29:20]), 'h2CC);
    check("guard4_ch3", int'(sym4[39:30]), 'h133);
    check_model();

    // random stream with random en and a mid-stream reset
    for (int k = 0; k < 600; k++) begin
      logic       e;
      logic [1:0] m;
      e = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(0, 3));
      step(e, m, $urandom, 8'($urandom), 16'($urandom));
      check_model();
      if (k == 300) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_values("midreset");
        step(1'b0, 2'b00, $urandom, 8'($urandom), 16'($urandom));
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
